iodelay_cal_ctrl: RTL
=====================

# iodelay_cal_ctrl

Input-delay calibration controller for the source-synchronous DDR receive path. It sweeps the per-lane input delay tap across its full range while the link transmits a static training pattern, and checks the DDR input's rising/falling samples against that pattern at each tap. It then loads the centre of the longest passing window and reports lock. It sits between the DDR input capture stage (whose `q1`/`q2` outputs it observes) and the delay element tap control, in the captured-clock domain.

## Interface
- `WIDTH`, 5: data lanes observed per edge.
- `TAP_WIDTH`, 5: delay tap field width.
- `MAX_TAP`, 31: highest legal tap, ≤ 2^TAP_WIDTH−1.
- `SETTLE_CYCLES`, 8: wait after each tap load before sampling, ≥1.
- `SAMPLE_COUNT`, 64: words compared per tap, ≥1.
- `PATTERN_Q1`, 5'b01010: expected rising-edge word.
- `PATTERN_Q2`, 5'b10101: expected falling-edge word.
- `ERR_THRESH`, 4: consecutive mismatches that drop lock (tracking only).
- `clk`  in  1  capture clock, the DDR input's output clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin or restart a calibration sweep.
- `q1`  in  WIDTH  rising-edge sample from the DDR input.
- `q2`  in  WIDTH  falling-edge sample from the DDR input.
- `tap_value`  out  TAP_WIDTH  delay tap to apply.
- `tap_load`  out  1  one-cycle strobe; `tap_value` is valid in the same cycle.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when a sweep ends (pass or fail).
- `locked`  out  1  centre tap applied and valid.
- `cal_error`  out  1  last sweep found no passing tap.
- `win_start`  out  TAP_WIDTH  first tap of the chosen window.
- `win_len`  out  TAP_WIDTH+1  length of the chosen window.

## Operation
- States: IDLE, LOAD, SETTLE, CHECK, EVAL, FINAL, LOCKED, FAIL.
- IDLE: on `start`, go to LOAD with tap 0. Clear the window registers, `locked` and `cal_error`.
- LOAD: drive `tap_value`=tap and `tap_load`=1, then go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to CHECK.
- CHECK: for SAMPLE_COUNT cycles, test `q1`==PATTERN_Q1 && `q2`==PATTERN_Q2. Any mismatch marks the tap as failed.
- EVAL: update the run tracker. A passing tap extends the current run, or starts a new run at this tap. A failing tap, or the last tap (MAX_TAP), closes the run.
- Run selection: a closed run replaces the best run only if it is strictly longer, so ties keep the lower window.
- After EVAL: if tap<MAX_TAP, go to LOAD with tap+1. Otherwise go to FINAL when best length>0, or FAIL when it is 0.
- FINAL: tap = win_start + (win_len−1)>>1, computed in TAP_WIDTH+1 bits with the result floored. Strobe `tap_load`, pulse `done`, then go to LOCKED with `locked`=1.
- FAIL: load tap 0 with `tap_load`, pulse `done`, set `cal_error`=1.
- LOCKED and FAIL hold until the next `start`, which begins a new sweep.
- `start` during a sweep (`busy`=1) is ignored.
- Reset mid-sweep: returns to IDLE with all outputs at their reset values. No `tap_load` is issued.

## Timing
- Reset values: `tap_value`=0, `tap_load`=0, `busy`=0, `done`=0, `locked`=0, `cal_error`=0, `win_start`=0, `win_len`=0.
- All outputs are registered.
- `busy` rises the cycle after `start` is sampled and falls in the cycle `done` pulses.
- Per tap: 2+SETTLE_CYCLES+SAMPLE_COUNT cycles.
- Total from `start` to `done`: 1 + (MAX_TAP+1)·(2+SETTLE_CYCLES+SAMPLE_COUNT) + 1 cycles. With defaults this is 32·74+2 = 2370 cycles.
- `win_start` and `win_len` update in FINAL/FAIL and are stable while `done`=1.

## Configuration
- `IODELAY_CAL_TRACK_EN` defined: LOCKED keeps comparing every cycle.
  - ERR_THRESH consecutive mismatching words clear `locked` and restart the sweep automatically (go to LOAD with tap 0, `busy`=1).
  - A single matching word resets the mismatch counter.
- Not defined: LOCKED ignores `q1`/`q2`, and `locked` stays 1 until the next `start` or reset.

## Structure
- Shared package `iodelay_cal_pkg` holds:
  - the state encoding;
  - default pattern constants;
  - a function computing the centre tap.
- Sub-module `iodelay_cal_window` holds the run tracker: current start/length, best start/length, and the close/compare logic. It is driven by `eval`, `pass`, `last` and `clear` strobes.

## Test plan
- Pattern valid only at taps 10–20 → `done` after 2370 cycles; `win_start`=10, `win_len`=11, final `tap_load` with `tap_value`=15, `locked`=1.
- Pattern never valid → `cal_error`=1, `locked`=0, `win_len`=0, final `tap_value`=0.
- Passing taps 3–6 and 20–23 (tie) → `win_start`=3, `tap_value`=4.
- Passing taps 28–31 (window closes at MAX_TAP) → `win_start`=28, `win_len`=4, `tap_value`=29.
- Deassert `rst_n` at cycle 500 of a sweep → all outputs 0 in the same cycle; next `start` sweeps from tap 0; a `start` pulse mid-sweep has no effect.
- With `IODELAY_CAL_TRACK_EN` and lock at tap 15:
  - 3 bad words then a good one → lock kept;
  - 4 consecutive bad words → `locked`=0 and `busy`=1 on the next cycle, with `tap_load` at tap 0.

Source files
------------

// File: rtl/iodelay_cal_pkg.sv
`default_nettype none
// iodelay_cal_pkg: state encoding, default training patterns and the centre-tap helper
// shared by the input-delay calibration controller and its window tracker.
package iodelay_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_EVAL   = 3'd4,
    ST_FINAL  = 3'd5,
    ST_LOCKED = 3'd6,
    ST_FAIL   = 3'd7
  } cal_state_t;

  localparam logic [4:0] DEF_PATTERN_Q1 = 5'b01010;
  localparam logic [4:0] DEF_PATTERN_Q2 = 5'b10101;

  // Centre of a window, rounding down for even lengths.
  function automatic int centre_tap(input int start, input int len);
    if (len == 0) return start;
    return start + ((len - 1) / 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iodelay_cal_window.sv
`default_nettype none
// iodelay_cal_window: tracks the current run of passing taps and keeps the longest
// one seen so far; ties keep the earlier (lower) window.
module iodelay_cal_window #(
  parameter int TAP_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 eval,
  input  logic                 pass,
  input  logic                 last,
  input  logic [TAP_WIDTH-1:0] tap,
  output logic [TAP_WIDTH-1:0] best_start,
  output logic [TAP_WIDTH:0]   best_len,
  output logic                 found
);

  logic [TAP_WIDTH-1:0] cur_start;
  logic [TAP_WIDTH:0]   cur_len;
  logic [TAP_WIDTH-1:0] run_start;
  logic [TAP_WIDTH:0]   run_len;
  logic                 closing;

  always_comb begin
    run_start = cur_start;
    run_len   = cur_len;
    if (pass) begin
      if (cur_len == '0) run_start = tap;
      run_len = cur_len + (TAP_WIDTH+1)'(1);
    end
    closing = !pass || last;
  end

  // Only meaningful on the final tap, where every run is closed.
  assign found = (best_len != '0) || (run_len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (eval) begin
      if (closing) begin
        if (run_len > best_len) begin
          best_start <= run_start;
          best_len   <= run_len;
        end
        cur_start <= '0;
        cur_len   <= '0;
      end else begin
        cur_start <= run_start;
        cur_len   <= run_len;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/iodelay_cal_ctrl.sv
`default_nettype none
// iodelay_cal_ctrl: sweeps the input-delay tap, finds the longest passing window and loads its centre.
// Define IODELAY_CAL_TRACK_EN to keep checking the pattern while locked and re-sweep on repeated errors.
module iodelay_cal_ctrl
  import iodelay_cal_pkg::*;
#(
  parameter int               WIDTH         = 5,
  parameter int               TAP_WIDTH     = 5,
  parameter int               MAX_TAP       = 31,
  parameter int               SETTLE_CYCLES = 8,
  parameter int               SAMPLE_COUNT  = 64,
  parameter logic [WIDTH-1:0] PATTERN_Q1    = DEF_PATTERN_Q1,
  parameter logic [WIDTH-1:0] PATTERN_Q2    = DEF_PATTERN_Q2,
  parameter int               ERR_THRESH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     q1,
  input  logic [WIDTH-1:0]     q2,
  output logic [TAP_WIDTH-1:0] tap_value,
  output logic                 tap_load,
  output logic                 busy,
  output logic                 done,
  output logic                 locked,
  output logic                 cal_error,
  output logic [TAP_WIDTH-1:0] win_start,
  output logic [TAP_WIDTH:0]   win_len
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     SAMPLE_LAST = CNT_W'(SAMPLE_COUNT - 1);
  localparam logic [TAP_WIDTH-1:0] TAP_LAST    = TAP_WIDTH'(MAX_TAP);

  cal_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic                 tap_ok;
  logic                 word_ok;
  logic                 sweep_go;
  logic                 track_restart;
  logic [TAP_WIDTH-1:0] best_start;
  logic [TAP_WIDTH:0]   best_len;
  logic                 found;
  logic [TAP_WIDTH-1:0] centre;

  assign word_ok  = (q1 == PATTERN_Q1) && (q2 == PATTERN_Q2);
  // busy is low only in IDLE, LOCKED and the holding part of FAIL, so start is ignored mid-sweep.
  assign sweep_go = (start && !busy) || track_restart;
  assign centre   = TAP_WIDTH'(centre_tap(int'(best_start), int'(best_len)));

`ifdef IODELAY_CAL_TRACK_EN
  localparam int                ERR_W    = $clog2(ERR_THRESH + 1);
  localparam logic [ERR_W-1:0]  ERR_LAST = ERR_W'(ERR_THRESH - 1);
  logic [ERR_W-1:0] err_cnt;

  assign track_restart = (state == ST_LOCKED) && !word_ok && (err_cnt == ERR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (state != ST_LOCKED || word_ok || track_restart) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end
`else
  assign track_restart = 1'b0;
`endif

  iodelay_cal_window #(
    .TAP_WIDTH (TAP_WIDTH)
  ) u_window (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (sweep_go),
    .eval       (state == ST_EVAL),
    .pass       (tap_ok),
    .last       (tap_value == TAP_LAST),
    .tap        (tap_value),
    .best_start (best_start),
    .best_len   (best_len),
    .found      (found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tap_ok    <= 1'b0;
      tap_value <= '0;
      tap_load  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      locked    <= 1'b0;
      cal_error <= 1'b0;
      win_start <= '0;
      win_len   <= '0;
    end else begin
      tap_load <= 1'b0;
      done     <= 1'b0;
      if (sweep_go) begin
        state     <= ST_LOAD;
        cnt       <= '0;
        tap_ok    <= 1'b1;
        tap_value <= '0;
        tap_load  <= 1'b1;
        busy      <= 1'b1;
        locked    <= 1'b0;
        cal_error <= 1'b0;
        win_start <= '0;
        win_len   <= '0;
      end else begin
        case (state)
          ST_LOAD: begin
            cnt   <= '0;
            state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt   <= '0;
              state <= ST_CHECK;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_CHECK: begin
            if (!word_ok) tap_ok <= 1'b0;
            if (cnt == SAMPLE_LAST) state <= ST_EVAL;
            else                    cnt   <= cnt + CNT_W'(1);
          end
          ST_EVAL: begin
            if (tap_value != TAP_LAST) begin
              tap_value <= tap_value + TAP_WIDTH'(1);
              tap_load  <= 1'b1;
              tap_ok    <= 1'b1;
              state     <= ST_LOAD;
            end else begin
              state <= found ? ST_FINAL : ST_FAIL;
            end
          end
          ST_FINAL: begin
            tap_value <= centre;
            tap_load  <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            locked    <= 1'b1;
            win_start <= best_start;
            win_len   <= best_len;
            state     <= ST_LOCKED;
          end
          ST_FAIL: begin
            // First FAIL cycle reports; afterwards the state simply holds.
            if (busy) begin
              tap_value <= '0;
              tap_load  <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              cal_error <= 1'b1;
              win_start <= best_start;
              win_len   <= best_len;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
